// File: rtl/axi4s_packet_encoder.sv
// Byte-stuffing packet framer: wraps each AXI4-Stream packet in START/STOP
// delimiters and escapes payload bytes that collide with the delimiter set.
module axi4s_packet_encoder #(
    parameter logic [7:0] START_BYTE  = 8'h7D,
    parameter logic [7:0] STOP_BYTE   = 8'h7E,
    parameter logic [7:0] ESCAPE_BYTE = 8'h7F
) (
    input  logic       aclk,
    input  logic       areset,
    input  logic       in_tvalid,
    output logic       in_tready,
    input  logic [7:0] in_tdata,
    input  logic       in_tkeep,
    input  logic       in_tlast,
    output logic       out_tvalid,
    input  logic       out_tready,
    output logic [7:0] out_tdata,
    output logic       out_tkeep
);

    typedef enum logic [1:0] {IDLE, DATA, ESC, STOP} state_t;

    state_t     state, state_nxt;
    logic [7:0] esc_byte;
    logic       esc_last;
    logic       out_free;
    logic       is_special;
    logic       load;
    logic [7:0] load_data;
    logic       store;

    assign out_free   = !out_tvalid || out_tready;
    assign out_tkeep  = 1'b1;
    assign is_special = (in_tdata == START_BYTE) || (in_tdata == STOP_BYTE) ||
                        (in_tdata == ESCAPE_BYTE);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_data = '0;
        store     = 1'b0;
        in_tready = (state == DATA) && out_free;
        case (state)
            IDLE: begin
                // START is emitted on sight of a beat; the beat itself waits for DATA
                if (in_tvalid && out_free) begin
                    load      = 1'b1;
                    load_data = START_BYTE;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (in_tvalid && out_free) begin
                    if (in_tkeep && is_special) begin
                        load      = 1'b1;
                        load_data = ESCAPE_BYTE;
                        store     = 1'b1;
                        state_nxt = ESC;
                    end else if (in_tkeep) begin
                        load      = 1'b1;
                        load_data = in_tdata;
                        state_nxt = in_tlast ? STOP : DATA;
                    end else if (in_tlast) begin
                        load      = 1'b1;
                        load_data = STOP_BYTE;
                        state_nxt = IDLE;
                    end
                end
            end
            ESC: begin
                if (out_free) begin
                    load      = 1'b1;
                    load_data = esc_byte;
                    state_nxt = esc_last ? STOP : DATA;
                end
            end
            STOP: begin
                if (out_free) begin
                    load      = 1'b1;
                    load_data = STOP_BYTE;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state      <= IDLE;
            out_tvalid <= 1'b0;
            out_tdata  <= '0;
            esc_byte   <= '0;
            esc_last   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (out_free) begin
                out_tvalid <= load;
                if (load) out_tdata <= load_data;
            end
            if (store) begin
                esc_byte <= in_tdata;
                esc_last <= in_tlast;
            end
        end
    end

endmodule

// File: doc/axi4s_packet_encoder.md
AXI4S_PACKET_ENCODER -- requirements
Module: axi4s_packet_encoder

Interface
REQ-001 The block SHALL have parameter START_BYTE, default 8'h7D: frame start delimiter.
REQ-002 The block SHALL have parameter STOP_BYTE, default 8'h7E: frame stop delimiter.
REQ-003 The block SHALL have parameter ESCAPE_BYTE, default 8'h7F: escape prefix; all three parameter values SHALL be distinct.
REQ-004 aclk  input  1  sole clock; all logic on its rising edge.
REQ-005 areset  input  1  reset; asynchronous and active-high.
REQ-006 in_tvalid  input  1  packet beat valid.
REQ-007 in_tready  output  1  packet beat accepted when high together with in_tvalid.
REQ-008 in_tdata  input  8  packet payload byte.
REQ-009 in_tkeep  input  1  payload byte present; 0 = null beat.
REQ-010 in_tlast  input  1  last beat of packet.
REQ-011 out_tvalid  output  1  encoded byte valid; feeds the UART transmitter byte port.
REQ-012 out_tready  input  1  downstream accepts encoded byte.
REQ-013 out_tdata  output  8  encoded byte.
REQ-014 out_tkeep  output  1  constant 1.

Function
REQ-015 The block SHALL convert each input packet to: START_BYTE, encoded payload bytes, STOP_BYTE.
REQ-016 A payload byte equal to START_BYTE, STOP_BYTE or ESCAPE_BYTE SHALL be emitted as ESCAPE_BYTE followed by the unchanged byte; any other byte SHALL be emitted unchanged.
REQ-017 out_tvalid/out_tdata SHALL come from a single output register; "out_free" = !out_tvalid || out_tready.
REQ-018 Once out_tvalid is high, out_tdata SHALL hold stable until out_tready is sampled high.
REQ-019 FSM states SHALL be IDLE, DATA, ESC, STOP.
REQ-020 IDLE: when in_tvalid && out_free, load START_BYTE and go to DATA; the input beat SHALL NOT be consumed.
REQ-021 in_tready SHALL be combinational: high only in DATA && out_free.
REQ-022 DATA, accepted beat with tkeep=1 and a non-special byte: load the byte; go to STOP if tlast, else stay in DATA.
REQ-023 DATA, accepted beat with tkeep=1 and a special byte: load ESCAPE_BYTE, store the byte and tlast, go to ESC.
REQ-024 DATA, accepted beat with tkeep=0: drop the byte; if tlast, load STOP_BYTE and go to IDLE, else load nothing.
REQ-025 ESC: when out_free, load the stored byte; go to STOP if stored tlast, else to DATA.
REQ-026 STOP: when out_free, load STOP_BYTE and go to IDLE.
REQ-027 When out_free and nothing is loaded, out_tvalid SHALL clear.
REQ-028 Latency: START_BYTE appears on out_tdata the cycle after in_tvalid is first sampled in IDLE.
REQ-029 Throughput: with out_tready held at 1, one output byte per cycle with no bubbles.
REQ-030 An empty packet (single beat: tkeep=0, tlast=1) SHALL produce exactly START_BYTE, STOP_BYTE.
REQ-031 Back-to-back packets SHALL be encoded with no merged delimiters; each packet gets its own START/STOP.
REQ-032 out_tready low in any state SHALL stall the FSM without loss or duplication.

Reset
REQ-033 While areset is high: state=IDLE, out_tvalid=0, out_tdata=8'h00, in_tready=0, stored byte/last cleared.
REQ-034 Reset asserted mid-frame SHALL abort the frame; the frame SHALL NOT be resumed, and no STOP_BYTE SHALL be emitted for it.
REQ-035 After reset is released, the first output SHALL be the START_BYTE of a new frame.

Verification
REQ-036 Input packet {0x01,0x02,0x03(last)}, out_tready=1 -> output 7D,01,02,03,7E on 5 consecutive cycles.
REQ-037 Input packet {0x7E,0x41(last)} -> output 7D,7F,7E,41,7E.
REQ-038 Input packet {0x7F(last)} -> output 7D,7F,7F,7E; in_tready low during the ESC and STOP cycles.
REQ-039 Single beat tkeep=0, tlast=1 -> output 7D,7E only; a mid-packet tkeep=0 beat is dropped silently.
REQ-040 Random out_tready (50%) over 1000 random packets -> the decoded stream equals the input, and out_tdata is stable while out_tvalid && !out_tready.
REQ-041 areset pulsed after 7D,01 of a 4-byte packet -> out_tvalid=0 at once; the next packet starts with 7D and no 7E is emitted for the aborted frame.
